// File: rtl/uart_fifo_wr_arb.sv
// Round-robin arbiter sharing one UART FIFO write port among N_REQ byte-stream requesters.
// Latency: grant one wclk after a request is seen in IDLE; beats pass combinationally to the FIFO.
// Backpressure: fifo_wfull stalls the owner beat by beat; fifo_almost_full only blocks new grants.
module uart_fifo_wr_arb #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  input  logic                          fifo_wfull,
  input  logic                          fifo_almost_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [N_REQ-1:0]              grant,
  output logic                          busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_REQ-1:0] grant_q;
  logic [PW-1:0]    last_ptr;   // previous winner while idle, current owner while in XFER
  logic [BW-1:0]    beat_cnt;
  logic [PW-1:0]    sel;
  logic [PW-1:0]    cand;
  logic             sel_found;
  logic             start;
  logic             hs;
  logic             rel;

  // Round-robin scan: first valid requester after the previous winner, wrapping modulo N_REQ
  always_comb begin
    sel       = last_ptr;
    cand      = '0;
    sel_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = PW'((int'(last_ptr) + k) % N_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign start = (state == IDLE) && !fifo_almost_full && sel_found;
  assign hs    = (state == XFER) && req_valid[last_ptr] && !fifo_wfull;
  // A packet end and the burst limit landing on the same beat still give a single release
  assign rel   = hs && (req_last[last_ptr] || (beat_cnt == BW'(MAX_BURST - 1)));

  // State register
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: grant when arbitration wins, release on packet end or burst limit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = XFER;
      XFER:    if (rel)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, owner pointer and beat counter; last_ptr reset to N_REQ-1 so the first scan begins at 0
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      grant_q  <= '0;
      last_ptr <= PW'(N_REQ - 1);
      beat_cnt <= '0;
    end else if (start) begin
      grant_q  <= {{(N_REQ-1){1'b0}}, 1'b1} << sel;
      last_ptr <= sel;
      beat_cnt <= '0;
    end else if (hs) begin
      beat_cnt <= beat_cnt + 1'b1;
      if (rel) grant_q <= '0;
    end
  end

  // Outputs: owner path is combinational from the registered grant so a full FIFO never loses a beat
  always_comb begin
    req_ready  = '0;
    fifo_w_en  = 1'b0;
    fifo_wdata = '0;
    busy       = 1'b0;
    if (state == XFER) begin
      busy                = 1'b1;
      req_ready[last_ptr] = !fifo_wfull;
      fifo_w_en           = hs;
      fifo_wdata          = req_data[last_ptr*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_uart_fifo_wr_arb.sv
// Directed bench for uart_fifo_wr_arb: four byte-stream sources feeding one FIFO write port.
// Each source presents bytes data_of(i, pos) and advances pos on a sampled handshake.
// Writes are logged as owner*256+byte and compared against hand-built expected sequences.
module tb_uart_fifo_wr_arb;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_wfull;
  logic        fifo_almost_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_wdata;
  logic [3:0]  grant;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [3:0] src_en;
  logic [3:0] all_last;
  int         len [4];
  int         pos [4];
  int         wlog [$];

  uart_fifo_wr_arb #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(16)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_wfull(fifo_wfull),
    .fifo_almost_full(fifo_almost_full), .fifo_w_en(fifo_w_en),
    .fifo_wdata(fifo_wdata), .grant(grant), .busy(busy)
  );

  always #5 wclk = ~wclk;

  function automatic logic [7:0] data_of(int i, int j);
    return 8'(8'hA1 + (i - 1) * 64 + j);
  endfunction

  function automatic int owner_of(logic [3:0] g);
    int o;
    o = 15;
    for (int i = 0; i < 4; i++) if (g[i]) o = i;
    return o;
  endfunction

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_en[i] && pos[i] < len[i]) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = data_of(i, pos[i]);
        req_last[i]         = all_last[i] || (pos[i] == len[i] - 1);
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic clear_src();
    src_en   = 4'b0;
    all_last = 4'b0;
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      pos[i] = 0;
    end
    wlog.delete();
  endtask

  // One clock: sample handshakes/writes before the edge, advance sources after it
  task automatic tick();
    logic [3:0] hs_s;
    hs_s = req_valid & req_ready;
    if (fifo_w_en) wlog.push_back(owner_of(grant) * 256 + int'(fifo_wdata));
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) if (hs_s[i]) pos[i]++;
    drive();
    #1;
  endtask

  task automatic do_reset();
    wrst             = 1'b1;
    fifo_wfull       = 1'b0;
    fifo_almost_full = 1'b0;
    clear_src();
    drive();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
    @(posedge wclk);
    #2;
  endtask

  task automatic test_reset();
    wrst             = 1'b1;
    fifo_wfull       = 1'b0;
    fifo_almost_full = 1'b0;
    clear_src();
    src_en = 4'hF;
    for (int i = 0; i < 4; i++) len[i] = 4;
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge wclk);
      checks++;
      if ({grant, busy, req_ready, fifo_w_en, fifo_wdata} !== 18'd0) begin
        failures++;
        $display("FAIL reset_hold c=%0d got grant=%b busy=%b ready=%b wen=%b wdata=%h exp all 0",
                 c, grant, busy, req_ready, fifo_w_en, fifo_wdata);
      end
    end
    do_reset();
    checks++;
    if ({grant, busy, req_ready, fifo_w_en, fifo_wdata} !== 18'd0) begin
      failures++;
      $display("FAIL reset_after got grant=%b busy=%b ready=%b wen=%b wdata=%h exp all 0",
               grant, busy, req_ready, fifo_w_en, fifo_wdata);
    end
  endtask

  task automatic test_single();
    do_reset();
    src_en[1] = 1'b1;
    len[1]    = 3;
    drive();
    #1;
    checks++;
    if ({grant, busy, fifo_w_en} !== 6'b0000_0_0) begin
      failures++;
      $display("FAIL single_idle got grant=%b busy=%b wen=%b exp 0000 0 0", grant, busy, fifo_w_en);
    end
    for (int b = 0; b < 3; b++) begin
      tick();
      checks++;
      if ({grant, busy, fifo_w_en, req_ready, fifo_wdata} !== {4'b0010, 1'b1, 1'b1, 4'b0010, data_of(1, b)}) begin
        failures++;
        $display("FAIL single_beat%0d got grant=%b busy=%b wen=%b ready=%b wdata=%h exp 0010 1 1 0010 %h",
                 b, grant, busy, fifo_w_en, req_ready, fifo_wdata, data_of(1, b));
      end
    end
    tick();
    checks++;
    if ({grant, busy, fifo_w_en} !== 6'b0000_0_0) begin
      failures++;
      $display("FAIL single_release got grant=%b busy=%b wen=%b exp 0000 0 0", grant, busy, fifo_w_en);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    src_en   = 4'hF;
    all_last = 4'hF;
    for (int i = 0; i < 4; i++) len[i] = 8;
    drive();
    #1;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if ({grant, fifo_w_en, fifo_wdata} !== {4'(1 << (k % 4)), 1'b1, data_of(k % 4, k / 4)}) begin
        failures++;
        $display("FAIL rr_grant k=%0d got grant=%b wen=%b wdata=%h exp %b 1 %h",
                 k, grant, fifo_w_en, fifo_wdata, 4'(1 << (k % 4)), data_of(k % 4, k / 4));
      end
      tick();
      checks++;
      if ({grant, busy, fifo_w_en} !== 6'b0000_0_0) begin
        failures++;
        $display("FAIL rr_bubble k=%0d got grant=%b busy=%b wen=%b exp 0000 0 0", k, grant, busy, fifo_w_en);
      end
    end
  endtask

  task automatic test_burst();
    int exp_log [$];
    do_reset();
    src_en[2] = 1'b1;
    len[2]    = 40;
    drive();
    #1;
    tick();
    src_en[0] = 1'b1;
    len[0]    = 1;
    drive();
    #1;
    checks++;
    if (grant !== 4'b0100) begin
      failures++;
      $display("FAIL burst_first_grant got=%b exp=0100", grant);
    end
    repeat (60) tick();
    for (int j = 0; j < 16; j++)  exp_log.push_back(2 * 256 + int'(data_of(2, j)));
    exp_log.push_back(0 * 256 + int'(data_of(0, 0)));
    for (int j = 16; j < 40; j++) exp_log.push_back(2 * 256 + int'(data_of(2, j)));
    checks++;
    if (wlog.size() != exp_log.size()) begin
      failures++;
      $display("FAIL burst_count got=%0d exp=%0d", wlog.size(), exp_log.size());
    end
    for (int n = 0; n < exp_log.size() && n < wlog.size(); n++) begin
      checks++;
      if (wlog[n] != exp_log[n]) begin
        failures++;
        $display("FAIL burst_entry n=%0d got owner=%0d byte=%h exp owner=%0d byte=%h",
                 n, wlog[n] / 256, wlog[n] % 256, exp_log[n] / 256, exp_log[n] % 256);
      end
    end
  endtask

  task automatic test_last_at_limit();
    do_reset();
    src_en[1] = 1'b1;
    len[1]    = 16;
    src_en[3] = 1'b1;
    len[3]    = 1;
    drive();
    #1;
    repeat (30) tick();
    checks++;
    if (wlog.size() != 17) begin
      failures++;
      $display("FAIL limit_count got=%0d exp=17", wlog.size());
    end else begin
      for (int n = 0; n < 16; n++) begin
        checks++;
        if (wlog[n] != 1 * 256 + int'(data_of(1, n))) begin
          failures++;
          $display("FAIL limit_entry n=%0d got=%h exp=%h", n, wlog[n], 1 * 256 + int'(data_of(1, n)));
        end
      end
      checks++;
      if (wlog[16] != 3 * 256 + int'(data_of(3, 0))) begin
        failures++;
        $display("FAIL limit_next got=%h exp=%h", wlog[16], 3 * 256 + int'(data_of(3, 0)));
      end
    end
  endtask

  task automatic test_wfull();
    logic exp_wen;
    do_reset();
    src_en[0] = 1'b1;
    len[0]    = 8;
    drive();
    for (int c = 0; c < 20; c++) begin
      fifo_wfull = (c >= 4 && c < 9);
      #1;
      exp_wen = (c >= 1 && c <= 3) || (c >= 9 && c <= 13);
      checks++;
      if (fifo_w_en !== exp_wen) begin
        failures++;
        $display("FAIL wfull_wen c=%0d got=%b exp=%b", c, fifo_w_en, exp_wen);
      end
      if (fifo_wfull) begin
        checks++;
        if ({req_ready, busy} !== 5'b0000_1) begin
          failures++;
          $display("FAIL wfull_stall c=%0d got ready=%b busy=%b exp 0000 1", c, req_ready, busy);
        end
      end
      tick();
    end
    fifo_wfull = 1'b0;
    checks++;
    if (wlog.size() != 8) begin
      failures++;
      $display("FAIL wfull_count got=%0d exp=8", wlog.size());
    end else begin
      for (int n = 0; n < 8; n++) begin
        checks++;
        if (wlog[n] != int'(data_of(0, n))) begin
          failures++;
          $display("FAIL wfull_entry n=%0d got=%h exp=%h", n, wlog[n], int'(data_of(0, n)));
        end
      end
    end
  endtask

  task automatic test_almost_full();
    do_reset();
    fifo_almost_full = 1'b1;
    src_en[3] = 1'b1;
    len[3]    = 4;
    drive();
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({grant, busy} !== 5'b0000_0) begin
        failures++;
        $display("FAIL afull_block c=%0d got grant=%b busy=%b exp 0000 0", c, grant, busy);
      end
      tick();
    end
    fifo_almost_full = 1'b0;
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL afull_release_same got=%b exp=0000", grant);
    end
    tick();
    checks++;
    if ({grant, fifo_w_en, fifo_wdata} !== {4'b1000, 1'b1, data_of(3, 0)}) begin
      failures++;
      $display("FAIL afull_grant got grant=%b wen=%b wdata=%h exp 1000 1 %h",
               grant, fifo_w_en, fifo_wdata, data_of(3, 0));
    end
    fifo_almost_full = 1'b1;
    #1;
    checks++;
    if (fifo_w_en !== 1'b1) begin
      failures++;
      $display("FAIL afull_in_xfer got wen=%b exp=1", fifo_w_en);
    end
    tick();
    checks++;
    if ({fifo_w_en, fifo_wdata} !== {1'b1, data_of(3, 1)}) begin
      failures++;
      $display("FAIL afull_continue got wen=%b wdata=%h exp 1 %h", fifo_w_en, fifo_wdata, data_of(3, 1));
    end
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || wlog.size() != 4) begin
      failures++;
      $display("FAIL afull_done got busy=%b writes=%0d exp busy=0 writes=4", busy, wlog.size());
    end
    fifo_almost_full = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_en[2] = 1'b1;
    len[2]    = 4;
    drive();
    #1;
    tick();
    tick();
    checks++;
    if ({grant, fifo_w_en, fifo_wdata} !== {4'b0100, 1'b1, data_of(2, 1)}) begin
      failures++;
      $display("FAIL rstmid_beat2 got grant=%b wen=%b wdata=%h exp 0100 1 %h",
               grant, fifo_w_en, fifo_wdata, data_of(2, 1));
    end
    wrst = 1'b1;
    #1;
    checks++;
    if ({grant, busy, req_ready, fifo_w_en, fifo_wdata} !== 18'd0) begin
      failures++;
      $display("FAIL rstmid_async got grant=%b busy=%b ready=%b wen=%b wdata=%h exp all 0",
               grant, busy, req_ready, fifo_w_en, fifo_wdata);
    end
    @(negedge wclk);
    wrst      = 1'b0;
    pos[2]    = 0;
    src_en[0] = 1'b1;
    len[0]    = 1;
    src_en[3] = 1'b1;
    len[3]    = 1;
    drive();
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_idle got=%b exp=0000", grant);
    end
    @(posedge wclk);
    #2;
    checks++;
    if ({grant, fifo_wdata} !== {4'b0001, data_of(0, 0)}) begin
      failures++;
      $display("FAIL rstmid_first_grant got grant=%b wdata=%h exp 0001 %h", grant, fifo_wdata, data_of(0, 0));
    end
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_last_at_limit();
    test_wfull();
    test_almost_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
